// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: pin synchronisers and glitch filters, 11-bit frame
// checker with inter-bit timeout, E0/F0 prefix decoder and a FWFT event FIFO.
//
// state  | meaning
// IDLE   | waiting for a start bit on the next ps2_clk falling edge
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, then handing the byte on
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int CW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [7:0]    ev_code,
    output logic          ev_extended,
    output logic          ev_release,
    output logic          frame_err,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // index 0 carries ps2_clk, index 1 carries ps2_data
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               prev_clk_q, prev_clk_d;
    logic               fall_stb, bit_in;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d, byte_q, byte_d;
    logic               par_q, par_d, byte_vld_q, byte_vld_d;
    logic               ferr_q, ferr_d, clr_flags, timeout;
    logic [TW-1:0]      tmo_q, tmo_d;

    logic               ext_q, ext_d, rel_q, rel_d, push;
    logic [9:0]         push_entry;

    logic [FIFO_DEPTH-1:0][9:0] mem_q, mem_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d, full, pop, do_push;
    logic [9:0]         head;

    always_comb begin
        sync1_d = {ps2_data, ps2_clk};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fcnt_d  = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FLT_LAST) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
        end
        prev_clk_d = filt_q[0];
    end

    assign fall_stb = prev_clk_q & ~filt_q[0];
    assign bit_in   = filt_q[1];

    // The counter only runs mid-frame; every falling edge restarts it.
    always_comb begin
        tmo_d   = tmo_q;
        timeout = 1'b0;
        if (state_q == IDLE || fall_stb) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            timeout = 1'b1;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        clr_flags  = 1'b0;
        if (fall_stb) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {bit_in, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (bit_in && (^{shift_q, par_q})) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        ferr_d    = 1'b1;
                        clr_flags = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (timeout) begin
            state_d   = IDLE;
            ferr_d    = 1'b1;
            clr_flags = 1'b1;
        end
    end

    always_comb begin
        ext_d      = ext_q;
        rel_d      = rel_q;
        push       = 1'b0;
        push_entry = {byte_q, ext_q, rel_q};
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
        if (clr_flags) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full    = (count_q == DEPTH_C);
    assign pop     = ev_valid & ev_ready;
    assign do_push = push & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push & full & ~pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            prev_clk_q <= 1'b1;
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            prev_clk_q <= prev_clk_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign ev_valid    = (count_q != '0);
    assign ev_code     = ev_valid ? head[9:2] : 8'h00;
    assign ev_extended = ev_valid & head[1];
    assign ev_release  = ev_valid & head[0];
    assign frame_err   = ferr_q;
    assign overflow    = ovf_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: a 10 kHz PS/2 device model on a 2 MHz
// system clock, checked with immediate assertions against hand-computed values.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

    logic       clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0;
    logic       ev_valid, ev_extended, ev_release, frame_err, overflow;
    logic [7:0] ev_code;
    logic [2:0] fifo_count;

    int n_asserts = 0, n_fail = 0;
    int ferr_cnt = 0, ovf_cnt = 0;
    int lat, base_e, base_o, first;

    ps2_key_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(1000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_extended(ev_extended), .ev_release(ev_release),
        .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #250 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overflow)  ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set mid-high, clock low 100 cycles, optional short
    // low glitch in the following high phase, optional one-cycle ev_ready pulse.
    task automatic send_bit(input logic b, input int g, input int rdy);
        ps2_data = b;
        repeat (50) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (lat < 0 && ev_valid) lat = i;
            if (i == rdy) ev_ready = 1'b1;
            else if (i == rdy + 1) ev_ready = 1'b0;
        end
        ps2_clk = 1'b1;
        if (g > 0) begin
            repeat (20) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (30 - g) @(negedge clk);
        end else begin
            repeat (50) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop,
                              input logic glitch, input int rdy);
        logic [10:0] bits;
        bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        lat  = -1;
        for (int i = 0; i < 11; i++)
            send_bit(bits[i], glitch ? 1 + (i % 3) : 0, (i == 10) ? rdy : -1);
        ps2_data = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] code, input logic ext, input logic rel);
        check({tag, "_valid"}, ev_valid, 1);
        check({tag, "_code"}, ev_code, code);
        check({tag, "_ext"}, ev_extended, ext);
        check({tag, "_rel"}, ev_release, rel);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", ev_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_code", ev_code, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // single make code, with exact STOP-to-valid latency
        send_frame(8'h1C, 0, 0, 0, -1);
        check("t1_latency", lat, 8);
        check("t1_count", fifo_count, 1);
        pop_check("t1", 8'h1C, 0, 0);
        check("t1_empty", ev_valid, 0);
        check("t1_count0", fifo_count, 0);
        check("t1_ferr", ferr_cnt, 0);

        // prefixes
        send_frame(8'hF0, 0, 0, 0, -1);
        check("t2_prefix_nopush", fifo_count, 0);
        send_frame(8'h1C, 0, 0, 0, -1);
        send_frame(8'hE0, 0, 0, 0, -1);
        send_frame(8'hF0, 0, 0, 0, -1);
        send_frame(8'h74, 0, 0, 0, -1);
        check("t2_count", fifo_count, 2);
        pop_check("t2_a", 8'h1C, 0, 1);
        pop_check("t2_b", 8'h74, 1, 1);
        send_frame(8'h1C, 0, 0, 0, -1);
        pop_check("t2_clr", 8'h1C, 0, 0);

        // bad parity, bad stop
        base_e = ferr_cnt;
        send_frame(8'h1C, 1, 0, 0, -1);
        check("t3_par_err", ferr_cnt - base_e, 1);
        send_frame(8'h1C, 0, 1, 0, -1);
        check("t3_stop_err", ferr_cnt - base_e, 2);
        check("t3_noev", fifo_count, 0);
        send_frame(8'h1C, 0, 0, 0, -1);
        pop_check("t3_recover", 8'h1C, 0, 0);

        // timeout after start + 5 data bits of 0x1C
        base_e = ferr_cnt;
        lat = -1;
        send_bit(0, 0, -1);
        send_bit(0, 0, -1);
        send_bit(0, 0, -1);
        send_bit(1, 0, -1);
        send_bit(1, 0, -1);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        ps2_clk = 1'b0;
        first = -1;
        for (int i = 1; i <= 1300; i++) begin
            @(negedge clk);
            if (frame_err && first < 0) first = i;
            if (i == 100) ps2_clk = 1'b1;
        end
        check("t4_tmo_time", first, 1007);
        check("t4_tmo_pulses", ferr_cnt - base_e, 1);
        check("t4_noev", fifo_count, 0);
        send_frame(8'h1C, 0, 0, 0, -1);
        pop_check("t4_recover", 8'h1C, 0, 0);

        // FIFO full and overflow
        base_o = ovf_cnt;
        send_frame(8'h15, 0, 0, 0, -1);
        send_frame(8'h1D, 0, 0, 0, -1);
        send_frame(8'h24, 0, 0, 0, -1);
        send_frame(8'h2D, 0, 0, 0, -1);
        check("t5_full", fifo_count, 4);
        check("t5_no_ovf_yet", ovf_cnt - base_o, 0);
        send_frame(8'h2C, 0, 0, 0, -1);
        check("t5_full_kept", fifo_count, 4);
        check("t5_ovf", ovf_cnt - base_o, 1);
        pop_check("t5_d0", 8'h15, 0, 0);
        pop_check("t5_d1", 8'h1D, 0, 0);
        pop_check("t5_d2", 8'h24, 0, 0);
        pop_check("t5_d3", 8'h2D, 0, 0);
        check("t5_drained", ev_valid, 0);

        // simultaneous push and pop when full
        base_o = ovf_cnt;
        send_frame(8'h15, 0, 0, 0, -1);
        send_frame(8'h1D, 0, 0, 0, -1);
        send_frame(8'h24, 0, 0, 0, -1);
        send_frame(8'h2D, 0, 0, 0, -1);
        send_frame(8'h2C, 0, 0, 0, 7);
        check("t5b_count", fifo_count, 4);
        check("t5b_no_ovf", ovf_cnt - base_o, 0);
        pop_check("t5b_d0", 8'h1D, 0, 0);
        pop_check("t5b_d1", 8'h24, 0, 0);
        pop_check("t5b_d2", 8'h2D, 0, 0);
        pop_check("t5b_d3", 8'h2C, 0, 0);

        // glitches in IDLE and mid-frame
        base_e = ferr_cnt;
        for (int g = 1; g <= 3; g++) begin
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        check("t6_idle_glitch_ferr", ferr_cnt - base_e, 0);
        check("t6_idle_glitch_ev", ev_valid, 0);
        send_frame(8'h1C, 0, 0, 1, -1);
        check("t6_glitch_ferr", ferr_cnt - base_e, 0);
        pop_check("t6_glitch", 8'h1C, 0, 0);

        // reset mid-frame with a queued event
        send_frame(8'h2C, 0, 0, 0, -1);
        check("t7_queued", fifo_count, 1);
        lat = -1;
        send_bit(0, 0, -1);
        send_bit(1, 0, -1);
        send_bit(0, 0, -1);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        check("t7_rst_valid", ev_valid, 0);
        check("t7_rst_count", fifo_count, 0);
        check("t7_rst_code", ev_code, 0);
        check("t7_rst_ferr", frame_err, 0);
        base_e = ferr_cnt;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h24, 0, 0, 0, -1);
        check("t7_no_ferr", ferr_cnt - base_e, 0);
        check("t7_count", fifo_count, 1);
        pop_check("t7_after", 8'h24, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Fully synchronous, parametrised PS/2 keyboard receiver for the clk domain.
- Oversamples ps2_clk and ps2_data, filters glitches, and frames 11-bit packets with start, parity and stop checks plus an inter-bit timeout.
- Decodes E0/F0 scan-code prefixes into key events and buffers them in a first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the PS/2 pins and the editor input logic, replacing the PS/2-clock-domain keycode capture.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered ps2_clk/ps2_data level changes (>=1).
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge, while mid-frame, before the frame is aborted.
- FIFO_DEPTH, 8: event FIFO entries (power of two, >=2).
- CW, $clog2(FIFO_DEPTH+1): width of fifo_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- ev_valid  out  1  FIFO non-empty; head event presented
- ev_ready  in  1  consumer accepts head event when ev_valid&&ev_ready
- ev_code  out  8  scan code of head event
- ev_extended  out  1  head event was preceded by E0
- ev_release  out  1  head event was preceded by F0 (break)
- frame_err  out  1  one-cycle pulse: parity, start, stop or timeout failure
- overflow  out  1  one-cycle pulse: completed event dropped because FIFO full
- fifo_count  out  CW  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, prefix flags clear, synchronisers and filters preset to 1 (bus idle), timeout counter 0. Reset mid-frame discards the partial frame with no frame_err.
- Input path: 2-flop synchroniser per pin, then a saturating filter. A filtered level changes only after FILTER_LEN consecutive equal synchronised samples. A fall-edge strobe fires on the clk cycle in which filtered ps2_clk goes 1->0. Filtered ps2_data is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe, if data==0 (start bit), go to DATA with bit index 0. If data==1, stay in IDLE and assert frame_err.
  - DATA: shift LSB first; after bit 7 (index wraps 7->0), go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: on strobe, the frame is good iff the stop bit is 1 and the 8 data bits plus parity have odd total ones. Good frame -> byte goes to the decoder, FSM returns to IDLE. Bad frame -> frame_err pulse, byte discarded, prefix flags cleared, FSM returns to IDLE.
- Timeout: the counter resets on every strobe and increments while FSM != IDLE. On reaching TIMEOUT_CYCLES it asserts frame_err, clears prefix flags, returns to IDLE and resets the counter. In IDLE the counter is held at 0.
- Decoder, acting on a good byte in the cycle after the STOP strobe:
  - 0xE0 sets ext_flag.
  - 0xF0 sets rel_flag.
  - Any other byte forms the event {code, ext_flag, rel_flag}, requests a FIFO push, and clears both flags in the same cycle.
  - Prefixes never push. Repeated prefixes are idempotent.
- FIFO: first-word-fall-through. ev_valid = (count != 0). ev_code/ev_extended/ev_release reflect the head entry and are 0 when empty.
  - A pop occurs when ev_valid && ev_ready.
  - A push when not full is written; count +1.
  - A push when full with no pop is dropped, count is unchanged, and overflow pulses one cycle.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty is impossible (ev_valid=0), so only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: first ev_valid rises 2 cycles after the STOP strobe (decode cycle, then FIFO write), independent of FILTER_LEN. End to end from the raw pin edge adds the 2-cycle synchroniser plus FILTER_LEN cycles.
- frame_err and overflow may pulse in the same cycle; each is independent.

Test Plan:
- Frame 0x1C (data LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 10 kHz PS/2 clock -> exactly one event ev_code=0x1C, ext=0, rel=0; fifo_count=1; pop with ev_ready -> ev_valid=0.
- Bytes F0,1C then E0,F0,74 -> two events, {0x1C,ext0,rel1} then {0x74,ext1,rel1}; no events for prefixes; flags clear afterwards (a following 0x1C gives ext0,rel0).
- Frame 0x1C with parity bit 1, then one with stop bit 0 -> frame_err pulses twice, no events, FSM back in IDLE, and a following good 0x1C is received.
- TIMEOUT_CYCLES=1000: start bit plus 5 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES cycles after the last strobe. A subsequent full 0x1C frame is received correctly.
- FIFO_DEPTH=4, ev_ready=0, send keys 0x15,0x1D,0x24,0x2D,0x2C -> fifo_count=4, overflow pulses once on the 5th key. Drain -> order 0x15,0x1D,0x24,0x2D. Repeat with ev_ready=1 held during the 5th push -> no overflow.
- FILTER_LEN=4: ps2_clk low glitches of 1-3 clk cycles during IDLE and mid-frame -> no strobe, no frame_err, frame decoded correctly. Assert rst mid-frame -> all outputs 0 and the next frame decodes cleanly.
